// File: rtl/fd_queue_if.sv
// Fetch/decode handshake bundle for fd_queue.
// master = fetch/decode side, slave = the queue itself.
interface fd_queue_if #(
  parameter int N  = 32,
  parameter int AW = 32
);
  logic          valid_F;
  logic [N-1:0]  inst_F;
  logic [AW-1:0] pc_F;
  logic          ready_F;
  logic          stall_D;
  logic          flush_F;
  logic          valid_D;
  logic [N-1:0]  inst_D;
  logic [AW-1:0] pc_D;

  modport master (
    output valid_F, inst_F, pc_F, stall_D, flush_F,
    input  ready_F, valid_D, inst_D, pc_D
  );

  modport slave (
    input  valid_F, inst_F, pc_F, stall_D, flush_F,
    output ready_F, valid_D, inst_D, pc_D
  );
endinterface

// File: rtl/fd_queue.sv
// DEPTH-entry fetch-to-decode instruction queue with flush and stall.
// Optional perf counters (stall_cnt, flush_cnt) enabled by FD_QUEUE_PERF_EN.
module fd_queue #(
  parameter int N     = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fd_queue_if.slave                  q,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FD_QUEUE_PERF_EN
  ,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                flush_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [N+AW-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ready, valid, push, pop;

  // ready looks only at occupancy, never at a same-cycle pop
  assign ready     = (count_q < CW'(DEPTH));
  assign valid     = (count_q != '0);
  assign push      = q.valid_F && ready && !q.flush_F;
  assign pop       = valid && !q.stall_D && !q.flush_F;

  assign q.ready_F = ready;
  assign q.valid_D = valid;
  assign q.inst_D  = valid ? mem_q[rp_q][N+AW-1:AW] : '0;
  assign q.pc_D    = valid ? mem_q[rp_q][AW-1:0]    : '0;
  assign count     = count_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (q.flush_F) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {q.inst_F, q.pc_F};
  end

`ifdef FD_QUEUE_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid && q.stall_D && !q.flush_F && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (q.flush_F && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fd_queue.sv
// Scoreboard bench for fd_queue: directed test-plan phases then random traffic,
// checked each cycle against a queue-based reference model.
module tb_fd_queue;
  localparam int N     = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] count;
`ifdef FD_QUEUE_PERF_EN
  logic [15:0]   stall_cnt, flush_cnt;
  int            exp_stall = 0, exp_flush = 0;
`endif

  fd_queue_if #(.N(N), .AW(AW)) bus ();

  fd_queue #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .q         (bus),
    .count     (count)
`ifdef FD_QUEUE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [N+AW-1:0] exp_q[$];
  bit model_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain FIFO semantics sampled at each rising edge.
  always @(posedge clk) begin
    if (rst && model_en) begin
      automatic int  sz  = exp_q.size();
      automatic bit  psh = bus.valid_F && (sz < DEPTH) && !bus.flush_F;
      automatic bit  pp  = (sz != 0) && !bus.stall_D && !bus.flush_F;
`ifdef FD_QUEUE_PERF_EN
      if (sz != 0 && bus.stall_D && !bus.flush_F && exp_stall < 16'hFFFF) exp_stall++;
      if (bus.flush_F && exp_flush < 16'hFFFF) exp_flush++;
`endif
      if (bus.flush_F) exp_q.delete();
      else begin
        if (pp)  void'(exp_q.pop_front());
        if (psh) exp_q.push_back({bus.inst_F, bus.pc_F});
      end
    end
  end

  // Monitor: compare visible DUT state against the model head every cycle.
  always @(negedge clk) begin
    if (rst && model_en) begin
      automatic int sz = exp_q.size();
      chk("count",   64'(count),       64'(sz));
      chk("ready_F", 64'(bus.ready_F), 64'(sz < DEPTH));
      chk("valid_D", 64'(bus.valid_D), 64'(sz != 0));
      if (sz != 0) begin
        chk("inst_D", 64'(bus.inst_D), 64'(exp_q[0][N+AW-1:AW]));
        chk("pc_D",   64'(bus.pc_D),   64'(exp_q[0][AW-1:0]));
      end else begin
        chk("inst_D_bubble", 64'(bus.inst_D), 64'd0);
        chk("pc_D_bubble",   64'(bus.pc_D),   64'd0);
      end
`ifdef FD_QUEUE_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
`endif
    end
  end

  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit stall, input bit flush);
    bus.valid_F = v;
    bus.inst_F  = inst;
    bus.pc_F    = pc;
    bus.stall_D = stall;
    bus.flush_F = flush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.valid_F = 1'b0;
    bus.inst_F  = '0;
    bus.pc_F    = '0;
    bus.stall_D = 1'b0;
    bus.flush_F = 1'b0;
    #12;
    chk("rst_valid_D", 64'(bus.valid_D), 64'd0);
    chk("rst_inst_D",  64'(bus.inst_D),  64'd0);
    chk("rst_pc_D",    64'(bus.pc_D),    64'd0);
    chk("rst_ready_F", 64'(bus.ready_F), 64'd1);
    chk("rst_count",   64'(count),       64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_en = 1'b1;

    // Fill under stall, then drain in order
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h1111_1111 * (i + 1), 32'(4 * i), 1'b1, 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_head",  64'(bus.inst_D), 64'h1111_1111);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0);

    // Streaming push+pop across pointer wrap
    for (int i = 1; i <= 10; i++) step(1'b1, 32'(i), 32'(4 * i), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);

    // Flush wins over a concurrent push
    for (int i = 0; i < 3; i++) step(1'b1, 32'hA0 + 32'(i), 32'(i), 1'b1, 1'b0);
    step(1'b1, 32'hDEAD_0000, 32'h100, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ready", 64'(bus.ready_F), 64'd1);

    // Full with a same-cycle pop still rejects the push
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + 32'(i), 32'(i), 1'b1, 1'b0);
    step(1'b1, 32'h5555_5555, 32'h55, 1'b0, 1'b0);
    chk("fullpop_count", 64'(count), 64'd3);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);

    // Asynchronous reset pulse between edges at count = 2
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 32'hC1, 32'h10, 1'b1, 1'b0);
    step(1'b1, 32'hC2, 32'h14, 1'b1, 1'b0);
    chk("pre_reset_count", 64'(count), 64'd2);
    bus.valid_F = 1'b0;
    #1;
    rst = 1'b0;
    exp_q.delete();
`ifdef FD_QUEUE_PERF_EN
    exp_stall = 0;
    exp_flush = 0;
`endif
    #1;
    chk("async_valid_D", 64'(bus.valid_D), 64'd0);
    chk("async_count",   64'(count),       64'd0);
    chk("async_inst_D",  64'(bus.inst_D),  64'd0);
`ifdef FD_QUEUE_PERF_EN
    chk("async_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("async_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 32'hE0 + 32'(i), 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fd_queue.md
# fd_queue

Parametrised fetch-decode pipeline stage that replaces the single fetch-decode register with a DEPTH-entry instruction queue. Each entry carries an instruction and its PC. The fetch side uses a valid/ready handshake. The decode side sees the queue head, which stays put under stall_D, and flush_F discards all queued entries. The queue lets fetch run ahead while decode is stalled, and a branch redirect still costs exactly one flush cycle.

## Interface
- N, 32, instruction width in bits
- AW, 32, PC width in bits
- DEPTH, 4, number of queue entries; power of two, at least 2
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- valid_F  input  1  fetch presents an instruction this cycle
- inst_F  input  N  fetched instruction
- pc_F  input  AW  PC of inst_F
- ready_F  output  1  queue can accept an entry; equals count < DEPTH
- stall_D  input  1  decode cannot consume the head this cycle
- flush_F  input  1  discard all queued entries and any concurrent push
- valid_D  output  1  head entry is valid; equals count != 0
- inst_D  output  N  head instruction; 0 when valid_D = 0
- pc_D  output  AW  head PC; 0 when valid_D = 0
- count  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: circular buffer of DEPTH entries of {inst, pc}, with write pointer wp, read pointer rp and occupancy count.
- Both pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally.
- Push condition: valid_F && ready_F && !flush_F. It writes mem[wp], increments wp and increments count.
- Pop condition: valid_D && !stall_D && !flush_F. It increments rp and decrements count.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- ready_F depends only on count. It does not look ahead to a same-cycle pop, so there is no combinational path from stall_D to ready_F. When full, a same-cycle pop does not make room for a push.
- Flush takes priority over push and pop. At the next edge: count = 0, wp = rp = 0, and storage contents are don't-care.
- Push while full is ignored, because ready_F = 0. Fetch must hold valid_F, inst_F and pc_F until it sees ready_F = 1.
- While empty, stall_D has no effect.
- inst_D and pc_D come combinationally from mem[rp], gated to 0 when the queue is empty. The gating makes an empty stage read as an all-zero bubble.
- Reset (rst = 0) acts immediately, independent of clk. It sets count = 0, wp = rp = 0 and all perf counters to 0.
- Outputs during and after reset: valid_D = 0, inst_D = 0, pc_D = 0, ready_F = 1.
- A reset asserted mid-operation drops all entries with no partial update.

## Timing
- Latency when empty: an entry pushed at edge k is visible on valid_D, inst_D and pc_D after edge k, i.e. in cycle k+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained.
- Stall: the head stays stable for every cycle in which stall_D = 1. Pushes continue until count = DEPTH.
- Flush: with flush_F high in cycle k, valid_D = 0 and ready_F = 1 in cycle k+1. A push offered in cycle k is lost, and fetch must re-present from the redirect PC.
- Wrap-around: pointers roll over with no bubble. After any multiple of DEPTH pushes and pops, ordering is strictly FIFO.

## Configuration
- FD_QUEUE_PERF_EN defined:
  - Adds output stall_cnt (16 bits): increments on each cycle with valid_D && stall_D && !flush_F.
  - Adds output flush_cnt (16 bits): increments on each cycle with flush_F = 1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- FD_QUEUE_PERF_EN undefined: neither port nor its logic exists, and all other behaviour is identical.

## Test plan
- Reset and fill:
  - During rst = 0: valid_D = 0, inst_D = 0, ready_F = 1.
  - After release, push 0x11111111, 0x22222222, 0x33333333, 0x44444444 (pc 0x0, 0x4, 0x8, 0xC) with stall_D = 1.
  - Required: count = 4, ready_F = 0, inst_D = 0x11111111, pc_D = 0x0 throughout.
- Drain in order: from the full state, set stall_D = 0 with no pushes. inst_D reads 0x11111111, 0x22222222, 0x33333333, 0x44444444 on successive cycles, then valid_D = 0, inst_D = 0, count = 0.
- Streaming and wrap:
  - With DEPTH = 4, push and pop every cycle for 10 instructions, values 1 to 10.
  - Required: valid_D high from the cycle after the first push, inst_D = 1..10 in order, count stays 1, no entry lost across pointer wrap.
- Flush priority: with count = 3, assert flush_F together with valid_F (inst 0xDEAD0000) and stall_D = 0. Next cycle: count = 0, valid_D = 0, ready_F = 1, and 0xDEAD0000 never appears on inst_D.
- Full with pop: with count = 4, stall_D = 0 and valid_F = 1. In that cycle ready_F = 0 and the push is rejected. Next cycle count = 3 and ready_F = 1.
- Async reset mid-stream: drop rst for less than half a clock period at count = 2. valid_D goes 0 and count = 0 immediately, without a clock edge. With FD_QUEUE_PERF_EN defined, stall_cnt and flush_cnt read 0 afterwards.
